// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the 19-bit CPU: PC width, reset vector
// and the sequencer state encoding.
package cpu_ctrl_pkg;

    localparam int unsigned PC_W = 8;
    localparam logic [PC_W-1:0] RESET_VECTOR = 8'h00;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO with an occupancy pointer. Entries are not reset;
// only the pointer is, so a reset discards any pending returns.
module ras_stack #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH) + 1;
    localparam int unsigned IdxW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0] entry [RAS_DEPTH];
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic            do_push, do_pop;

    assign empty   = (ptr_q == '0);
    assign full    = (ptr_q == PtrW'(RAS_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Top of stack lives one below the pointer.
    assign top     = entry[IdxW'(ptr_q - PtrW'(1))];

    always_comb begin
        ptr_d = ptr_q;
        if (do_push) begin
            ptr_d = ptr_q + PtrW'(1);
        end else if (do_pop) begin
            ptr_d = ptr_q - PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            entry[ptr_q[IdxW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: BOOT/RUN/HALT FSM, prioritised control-flow mux feeding
// the pc register, and sticky RAS error flags.
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W         = cpu_ctrl_pkg::PC_W,
    parameter int unsigned     RAS_DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_VECTOR = cpu_ctrl_pkg::RESET_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            halt,
    input  logic            resume,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            call,
    input  logic            ret,
    input  logic            clr_flags,
    output logic [PC_W-1:0] next_pc,
    output logic            pcwrite,
    output logic [1:0]      state,
    output logic            halted,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    state_e          state_q, state_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            set_ovf, set_unf;
    logic            push, pop, empty, full;
    logic [PC_W-1:0] top, pc_inc;

    assign pc_inc = pc + PC_W'(1);

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (top),
        .empty     (empty),
        .full      (full)
    );

    always_comb begin
        state_d = state_q;
        next_pc = pc;
        pcwrite = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (state_q)
            ST_BOOT: begin
                next_pc = RESET_VECTOR;
                pcwrite = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    // hold pc; requests ignored
                end else if (ret) begin
                    if (!empty) begin
                        next_pc = top;
                        pcwrite = 1'b1;
                        pop     = 1'b1;
                    end else begin
                        set_unf = 1'b1;
                        state_d = ST_HALT;
                    end
                end else if (call) begin
                    // A call into a full stack still jumps; only the push is lost.
                    next_pc = jump_target;
                    pcwrite = 1'b1;
                    push    = !full;
                    set_ovf = full;
                end else if (jump) begin
                    next_pc = jump_target;
                    pcwrite = 1'b1;
                end else if (branch_taken) begin
                    next_pc = branch_target;
                    pcwrite = 1'b1;
                end else begin
                    next_pc = pc_inc;
                    pcwrite = 1'b1;
                end
            end
            ST_HALT: begin
                if (!halt && resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        if (!rst_n) begin
            next_pc = RESET_VECTOR;
            pcwrite = 1'b0;
        end
    end

    // Set beats clear when both land in the same cycle.
    always_comb begin
        ovf_d = set_ovf | (ovf_q & ~clr_flags);
        unf_d = set_unf | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign state         = state_q;
    assign halted        = (state_q == ST_HALT);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a pc register model; expectations are
// queued per cycle and checked by a separate negedge monitor.
module tb_pc_sequencer;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] H = 2'b10;

    typedef struct packed {
        logic       pw;
        logic [7:0] npc;
        logic [1:0] st;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] pc;
    logic       stall, halt, resume, branch_taken, jump, call, ret, clr_flags;
    logic [7:0] branch_target, jump_target;
    logic [7:0] next_pc;
    logic       pcwrite, halted, ras_overflow, ras_underflow;
    logic [1:0] state;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    stim_done = 1'b0;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .stall         (stall),
        .halt          (halt),
        .resume        (resume),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .clr_flags     (clr_flags),
        .next_pc       (next_pc),
        .pcwrite       (pcwrite),
        .state         (state),
        .halted        (halted),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    // pc register driven by the sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 8'hAA;
        else if (pcwrite) pc <= next_pc;
    end

    task automatic idle();
        stall = 0; halt = 0; resume = 0; branch_taken = 0; jump = 0;
        call = 0; ret = 0; clr_flags = 0; branch_target = 8'h00; jump_target = 8'h00;
    endtask

    task automatic go(input string nm, input logic pw, input logic [7:0] npc,
                      input logic [1:0] st, input logic ovf, input logic unf);
        exp_t e;
        e = '{pw: pw, npc: npc, st: st, ovf: ovf, unf: unf};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic void chk(input string nm, input string fld,
                                input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got %02h, expected %02h", nm, fld, act, req);
        end
    endfunction

    // Monitor: compares every cycle an expectation is pending.
    initial begin : monitor
        exp_t  e;
        string nm;
        int    cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "pcwrite", {7'd0, pcwrite}, {7'd0, e.pw});
                chk(nm, "next_pc", next_pc, e.npc);
                chk(nm, "state", {6'd0, state}, {6'd0, e.st});
                chk(nm, "halted", {7'd0, halted}, {7'd0, (e.st == H)});
                chk(nm, "ovf", {7'd0, ras_overflow}, {7'd0, e.ovf});
                chk(nm, "unf", {7'd0, ras_underflow}, {7'd0, e.unf});
            end else if (stim_done || cyc > 2000) begin
                if (!stim_done) begin
                    n_err++;
                    $display("FAIL timeout: got no stimulus end, expected end within 2000 cycles");
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
    end

    initial begin : stim
        idle();
        #1 rst_n = 0;
        @(posedge clk); #1;
        go("rst", 0, 8'h00, B, 0, 0);
        rst_n = 1;
        go("boot", 1, 8'h00, B, 0, 0);
        go("run0", 1, 8'h01, R, 0, 0);
        go("run1", 1, 8'h02, R, 0, 0);
        // stall must also swallow a call: no push
        stall = 1; call = 1; jump_target = 8'hEE;
        go("stall0", 0, 8'h02, R, 0, 0);
        stall = 1;
        go("stall1", 0, 8'h02, R, 0, 0);
        go("unstall", 1, 8'h03, R, 0, 0);
        go("seq3", 1, 8'h04, R, 0, 0);
        go("seq4", 1, 8'h05, R, 0, 0);
        call = 1; jump_target = 8'h40;
        go("call40", 1, 8'h40, R, 0, 0);
        go("inc40", 1, 8'h41, R, 0, 0);
        go("inc41", 1, 8'h42, R, 0, 0);
        go("inc42", 1, 8'h43, R, 0, 0);
        ret = 1;
        go("ret06", 1, 8'h06, R, 0, 0);
        // five nested calls into a four-deep stack
        call = 1; jump_target = 8'h10; go("call1", 1, 8'h10, R, 0, 0);
        call = 1; jump_target = 8'h20; go("call2", 1, 8'h20, R, 0, 0);
        call = 1; jump_target = 8'h30; go("call3", 1, 8'h30, R, 0, 0);
        call = 1; jump_target = 8'h50; go("call4", 1, 8'h50, R, 0, 0);
        call = 1; jump_target = 8'h60; go("call5", 1, 8'h60, R, 0, 0);
        ret = 1; go("ret31", 1, 8'h31, R, 1, 0);
        ret = 1; go("ret21", 1, 8'h21, R, 1, 0);
        ret = 1; go("ret11", 1, 8'h11, R, 1, 0);
        ret = 1; go("ret07", 1, 8'h07, R, 1, 0);
        ret = 1; go("ret_empty", 0, 8'h07, R, 1, 0);
        go("halted", 0, 8'h07, H, 1, 1);
        clr_flags = 1; go("clr", 0, 8'h07, H, 1, 1);
        resume = 1; go("resume", 0, 8'h07, H, 0, 0);
        go("resumed", 1, 8'h08, R, 0, 0);
        jump = 1; jump_target = 8'hFF; go("jmpFF", 1, 8'hFF, R, 0, 0);
        go("wrap", 1, 8'h00, R, 0, 0);
        branch_taken = 1; branch_target = 8'h80; jump = 1; jump_target = 8'h90;
        go("br_jmp", 1, 8'h90, R, 0, 0);
        branch_taken = 1; branch_target = 8'hA0; go("br", 1, 8'hA0, R, 0, 0);
        call = 1; jump_target = 8'hC0; go("callC0", 1, 8'hC0, R, 0, 0);
        // ret beats call: pop only, so the stack is empty afterwards
        call = 1; jump_target = 8'hD0; ret = 1; go("ret_call", 1, 8'hA1, R, 0, 0);
        ret = 1; go("ret_empty2", 0, 8'hA1, R, 0, 0);
        halt = 1; resume = 1; go("halt_resume", 0, 8'hA1, H, 0, 1);
        resume = 1; go("resume2", 0, 8'hA1, H, 0, 1);
        go("resumed2", 1, 8'hA2, R, 0, 1);
        halt = 1; go("halt_run", 0, 8'hA2, R, 0, 1);
        go("halted2", 0, 8'hA2, H, 0, 1);
        resume = 1; go("resume3", 0, 8'hA2, H, 0, 1);
        go("resumed3", 1, 8'hA3, R, 0, 1);
        clr_flags = 1; go("clr2", 1, 8'hA4, R, 0, 1);
        // clear and new underflow together: set wins
        ret = 1; clr_flags = 1; go("clr_set", 0, 8'hA4, R, 0, 0);
        go("halted3", 0, 8'hA4, H, 0, 1);
        resume = 1; go("resume4", 0, 8'hA4, H, 0, 1);
        call = 1; jump_target = 8'hB0; go("callB0", 1, 8'hB0, R, 0, 1);
        call = 1; jump_target = 8'hB8; go("callB8", 1, 8'hB8, R, 0, 1);
        rst_n = 0;
        go("rst2", 0, 8'h00, B, 0, 0);
        rst_n = 1; jump = 1; jump_target = 8'h77;
        go("boot2", 1, 8'h00, B, 0, 0);
        ret = 1; go("ret_after_rst", 0, 8'h00, R, 0, 0);
        go("halted4", 0, 8'h00, H, 0, 1);
        stim_done = 1'b1;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the 8-bit program counter register of the 19-bit CPU. It computes next_pc and pcwrite every cycle from the current pc and the decoder's control-flow requests: sequential, branch, jump, call and return. It holds a small return-address stack (RAS) and a boot/run/halt state machine. It sits between the decode/control unit and the pc register; its next_pc and pcwrite drive that register directly.

Parameters:
PC_W, 8, program counter width
RAS_DEPTH, 4, number of return-address stack entries (power of 2)
RESET_VECTOR, 8'h00, first fetch address after reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc  input  PC_W  current value from the pc register
stall  input  1  hold pc this cycle (hazard or memory wait)
halt  input  1  enter HALT state
resume  input  1  leave HALT state, continue at pc+1
branch_taken  input  1  conditional branch resolved taken
branch_target  input  PC_W  branch destination
jump  input  1  unconditional jump
jump_target  input  PC_W  jump destination
call  input  1  subroutine call; jump_target is the destination
ret  input  1  return from subroutine
clr_flags  input  1  clear the sticky error flags
next_pc  output  PC_W  value the pc register loads
pcwrite  output  1  pc register load enable
state  output  2  00 BOOT, 01 RUN, 10 HALT
halted  output  1  state == HALT
ras_overflow  output  1  sticky: push attempted while the RAS was full
ras_underflow  output  1  sticky: pop attempted while the RAS was empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=BOOT, RAS pointer=0 (empty), ras_overflow=0, ras_underflow=0. The RAS contents are not reset.
- Output timing: next_pc and pcwrite are combinational from state, pc and the inputs. All state changes take effect at the rising edge of clk.
- While rst_n=0: next_pc=RESET_VECTOR, pcwrite=0.
- BOOT, one cycle only: next_pc=RESET_VECTOR, pcwrite=1. Go to RUN on the next edge. All request inputs are ignored.
- RUN: the first matching row applies, in this priority order:
  1. halt: pcwrite=0, next_pc=pc, go to HALT.
  2. stall: pcwrite=0, next_pc=pc. All requests are ignored; no RAS change.
  3. ret, RAS not empty: next_pc=top of stack, pcwrite=1, pop.
  4. ret, RAS empty: ras_underflow is set, pcwrite=0, go to HALT.
  5. call: next_pc=jump_target, pcwrite=1, push (pc+1) mod 2^PC_W. If the RAS is full, the push is dropped, ras_overflow is set, and the call itself still proceeds.
  6. jump: next_pc=jump_target, pcwrite=1.
  7. branch_taken: next_pc=branch_target, pcwrite=1.
  8. None of the above: next_pc=(pc+1) mod 2^PC_W, pcwrite=1. pc=8'hFF wraps to 8'h00.
- Simultaneous requests:
  - ret together with call: ret wins and no push occurs.
  - call together with jump: the call wins; both use jump_target.
- HALT:
  - pcwrite=0, next_pc=pc.
  - resume: go to RUN on the next edge. The first RUN cycle then sequences normally from pc.
  - halt has priority over resume if both are asserted.
- RAS:
  - LIFO with a pointer of $clog2(RAS_DEPTH)+1 bits.
  - Empty when the pointer is 0; full when the pointer is RAS_DEPTH.
  - A push writes entry[ptr] and then increments the pointer. A pop reads entry[ptr-1] and then decrements it.
- Sticky flags:
  - Set on the edge after the triggering cycle.
  - Cleared only by reset or by clr_flags.
  - If clr_flags and a new error occur in the same cycle, the set wins.
- Reset mid-operation clears the RAS pointer, discarding pending returns, and restarts with BOOT.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state encoding constants ST_BOOT, ST_RUN, ST_HALT
  - PC_W
  - RESET_VECTOR
- Sub-module ras_stack (parameters PC_W, RAS_DEPTH):
  - Inputs: push, pop, push_data.
  - Outputs: top, empty, full.
  - Resolves its own pointer update. The sequencer never asserts push and pop together.
- The FSM, the priority mux and the flag logic stay in pc_sequencer.

Test Plan:
- Reset, then release: BOOT cycle with next_pc=00 and pcwrite=1; next cycle state=RUN; with the pc register attached, pc steps 00,01,02,03 on successive edges.
- stall=1 for 2 cycles at pc=02: pcwrite=0 and pc holds 02 for both cycles; after release pc=03.
- At pc=05, call with jump_target=40: pc=40 and the RAS holds 06. Then 3 increments and ret: pc=06 and the RAS is empty.
- 5 nested calls with RAS_DEPTH=4: ras_overflow=1 after the 5th call, which still lands on its target. Then 4 rets return the 4 stored addresses in LIFO order. A 5th ret sets ras_underflow=1, gives halted=1, and pc holds.
- pc=FF with no request: next_pc=00. Also: branch_taken with jump asserted: jump_target is chosen. Also: ret with call asserted: pop only, no push.
- HALT then resume: pc is frozen while halted and continues at pc+1 afterwards. Also: assert rst_n=0 mid-sequence with 2 RAS entries: the RAS is empty afterwards, BOOT repeats, and next_pc=RESET_VECTOR.
